// File: rtl/cordic_pkg.sv
// Shared CORDIC types and constants: Q16.16 degree type, angle table, half-open phase wrap.
package cordic_pkg;

    typedef logic signed [31:0] deg_q16_t;

    localparam logic [31:0] DEG180_Q16 = 32'h00B40000;
    localparam logic [31:0] DEG360_Q16 = 32'h01680000;

    localparam logic signed [32:0] WRAP_HI  = $signed({1'b0, DEG180_Q16});
    localparam logic signed [32:0] WRAP_LO  = -WRAP_HI;
    localparam logic signed [32:0] WRAP_360 = $signed({1'b0, DEG360_Q16});

    // atan(2^-i) in degrees Q16.16, one entry per CORDIC stage
    function automatic deg_q16_t atan_q16(input int unsigned i);
        deg_q16_t a;
        case (i)
            0:       a = 32'sh002D0000;
            1:       a = 32'sh001A90A7;
            2:       a = 32'sh000E0947;
            3:       a = 32'sh00072001;
            4:       a = 32'sh0003938B;
            5:       a = 32'sh0001CA38;
            6:       a = 32'sh0000E52A;
            7:       a = 32'sh00007297;
            8:       a = 32'sh0000394C;
            9:       a = 32'sh00001CA6;
            10:      a = 32'sh00000E53;
            11:      a = 32'sh00000729;
            12:      a = 32'sh00000395;
            13:      a = 32'sh000001CA;
            14:      a = 32'sh000000E5;
            15:      a = 32'sh00000073;
            default: a = '0;
        endcase
        return a;
    endfunction

    // Input lies in (-360,360), so one correction lands it in [-180,180)
    function automatic deg_q16_t wrap_deg(input logic signed [32:0] v);
        logic signed [32:0] r;
        if (v >= WRAP_HI)
            r = v - WRAP_360;
        else if (v < WRAP_LO)
            r = v + WRAP_360;
        else
            r = v;
        return r[31:0];
    endfunction

endpackage

// File: rtl/cordic_tag_delay.sv
// Free-running DEPTH-stage shift register carrying {valid, tag} alongside the CORDIC pipeline.
// Latency DEPTH cycles; never stalls, no backpressure.
module cordic_tag_delay #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] sr [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
        end else begin
            sr[0] <= din;
            for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
    end

    assign dout = sr[DEPTH-1];

endmodule

// File: rtl/cordic_phase_post.sv
// CORDIC phase post-processor: quadrant restore, wrapped delta, optional averaged frequency
// (CORDIC_POST_FREQ_EN). Phase LAT+1, delta LAT+2, freq LAT+3 cycles after in_valid; no backpressure.
module cordic_phase_post
    import cordic_pkg::*;
#(
    parameter int LAT      = 16,
    parameter int AVG_LOG2 = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        x_neg,
    input  logic [31:0] phase_in,
    output logic [31:0] phase_out,
    output logic        phase_vld,
    output logic [31:0] delta_out,
    output logic        delta_vld,
    output logic [31:0] freq_out,
    output logic        freq_vld
);

    if (LAT < 1 || LAT > 32)          $error("LAT out of range 1..32");
    if (AVG_LOG2 < 0 || AVG_LOG2 > 6) $error("AVG_LOG2 out of range 0..6");

    logic [1:0]        tag;
    logic signed [32:0] phase_sum;
    logic signed [32:0] phase_diff;
    deg_q16_t          prev;
    logic              have_prev;

    cordic_tag_delay #(
        .DEPTH (LAT),
        .WIDTH (2)
    ) u_tag_delay (
        .clk  (clk),
        .rst  (rst),
        .din  ({in_valid, x_neg}),
        .dout (tag)
    );

    always_comb begin
        phase_sum  = $signed({phase_in[31], phase_in})
                   + (tag[0] ? $signed({1'b0, DEG180_Q16}) : 33'sd0);
        phase_diff = $signed({phase_out[31], phase_out}) - $signed({prev[31], prev});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_out <= '0;
            phase_vld <= 1'b0;
        end else begin
            phase_vld <= tag[1];
            if (tag[1]) phase_out <= wrap_deg(phase_sum);
        end
    end

    // prev follows every valid phase, gaps included, so deltas span consecutive samples
    always_ff @(posedge clk) begin
        if (rst) begin
            delta_out <= '0;
            delta_vld <= 1'b0;
            prev      <= '0;
            have_prev <= 1'b0;
        end else begin
            delta_vld <= phase_vld && have_prev;
            if (phase_vld) begin
                if (have_prev) delta_out <= wrap_deg(phase_diff);
                prev      <= phase_out;
                have_prev <= 1'b1;
            end
        end
    end

`ifdef CORDIC_POST_FREQ_EN
    localparam logic [6:0] CNT_LAST = 7'((1 << AVG_LOG2) - 1);

    deg_q16_t   acc;
    deg_q16_t   acc_sum;
    logic [6:0] cnt;

    assign acc_sum = acc + $signed(delta_out);

    // The closing delta is folded in directly so the window never needs an extra cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            cnt      <= '0;
            freq_out <= '0;
            freq_vld <= 1'b0;
        end else begin
            freq_vld <= 1'b0;
            if (delta_vld) begin
                if (cnt == CNT_LAST) begin
                    freq_out <= acc_sum >>> AVG_LOG2;
                    freq_vld <= 1'b1;
                    acc      <= '0;
                    cnt      <= '0;
                end else begin
                    acc <= acc_sum;
                    cnt <= cnt + 7'd1;
                end
            end
        end
    end
`else
    assign freq_out = '0;
    assign freq_vld = 1'b0;
`endif

endmodule

// File: doc/cordic_phase_post.md
# cordic_phase_post

Post-processor downstream of the 16-stage CORDIC vectoring pipeline. It restores the quadrant of the raw CORDIC phase using a sign tag issued alongside the CORDIC input, and emits a corrected phase in degrees Q16.16. It also emits a wrapped phase increment per sample and an averaged frequency estimate in degrees/sample, for use by the carrier/frequency-tracking logic.

## Interface
- LAT, 16: CORDIC latency in cycles, from the x/y sample edge to the valid phase on `phase_in`; range 1..32.
- AVG_LOG2, 4: frequency estimate averages 2^AVG_LOG2 deltas; range 0..6.

- clk  in  1  rising-edge clock, shared with the CORDIC
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  high in the cycle x/y are presented to the CORDIC
- x_neg  in  1  quadrant tag: upstream negated both x and y (original x<0); qualified by in_valid
- phase_in  in  32  raw CORDIC phase, signed degrees Q16.16; valid LAT cycles after in_valid
- phase_out  out  32  corrected phase, signed Q16.16, range [-180°,180°)
- phase_vld  out  1  one-cycle qualifier for phase_out
- delta_out  out  32  wrapped phase increment, signed Q16.16, range [-180°,180°)
- delta_vld  out  1  one-cycle qualifier for delta_out
- freq_out  out  32  averaged delta, signed Q16.16 degrees/sample
- freq_vld  out  1  one-cycle qualifier for freq_out

## Operation
- Tag delay line: {in_valid, x_neg}, LAT deep, free-running, with no stall and no backpressure.
- Stage S1, on a tagged-valid cycle: phase_out <= wrap(phase_in + (x_neg ? 180° : 0)). phase_vld pulses.
- wrap(v): if v ≥ 180° (0x00B40000), subtract 360° (0x01680000); if v < -180°, add 360°. The input range is (-360°,360°), so a single correction suffices.
- Stage S2, on phase_vld:
  - If have_prev is set: delta_out <= wrap(phase_out - prev) and delta_vld pulses.
  - In all cases: prev <= phase_out and have_prev <= 1.
  - The first sample after reset produces no delta.
- Stage S3 (compiled in by macro), on delta_vld: acc += delta_out and cnt++.
  - When cnt == 2^AVG_LOG2-1: freq_out <= (acc + delta_out) >>> AVG_LOG2 (arithmetic shift, truncating toward -inf); freq_vld pulses; acc and cnt clear in the same edge.
- Widths:
  - Internal sums are 33-bit signed before wrap.
  - acc is 32-bit signed; it cannot overflow because |delta| ≤ 2^23.5 and the count is ≤ 64.
- Back-to-back valid samples every cycle are fully supported.

## Timing
- in_valid at edge t gives phase_vld at t+LAT+1, delta_vld at t+LAT+2, and freq_vld at t+LAT+3 on the closing sample.
- Reset values: all outputs 0, all valids 0, delay line cleared, have_prev 0, prev 0, acc 0, cnt 0.
- Reset mid-operation: everything in flight is discarded. The first sample after reset sets have_prev and produces no delta. The averaging window restarts.
- Gaps in in_valid do not reset have_prev; the delta always spans consecutive valid samples.
- phase_in is ignored on cycles whose delayed tag is not valid.

## Configuration
- CORDIC_POST_FREQ_EN:
  - Defined: S3 averager is present.
  - Undefined: acc and cnt are removed; freq_out and freq_vld are tied to 0. Phase and delta paths are unchanged.

## Structure
- Shared package cordic_pkg holds:
  - DEG180_Q16 = 32'h00B40000
  - DEG360_Q16 = 32'h01680000
  - the wrap function
  - the Q16.16 degree typedef
- The CORDIC angle table constants move into cordic_pkg as well.
- One sub-module, cordic_tag_delay: a parameterised-depth shift register for {valid, tag}.

## Test plan
- LAT=16, x_neg=0, phase_in=0x002D0000 (45°) -> phase_out 0x002D0000 with phase_vld at t+17.
- x_neg=1, phase_in=0x001E0000 (30°) -> phase_out 0xFF6A0000 (-150°).
- Consecutive corrected phases 170°, then -170° -> delta_out 0x00140000 (+20°); the first sample after reset gives no delta_vld.
- AVG_LOG2=4, phase stepping +10° per cycle with wrap -> first freq_vld after the 17th valid sample, freq_out 0x000A0000, then every 16 samples.
- Assert rst for 1 cycle mid-stream -> all valids low the next cycle, no stale phase emerges, and the averaging window restarts from zero.
- Build without CORDIC_POST_FREQ_EN -> freq_vld stays 0 and phase/delta results are identical to the previous runs.
